unpack_sg_dma_chan: RTL
=======================

Name: unpack_sg_dma_chan

Overview:
Parametrised single-channel scatter-gather unpacker, the next generation of the 4-port unpack DMA. It buffers one ingress packet stream and segments each packet into fixed-size blocks at free-list addresses. It writes the blocks to the MMU and the block chain to the link-list SRAM, then emits one tag per packet from a tag FIFO. Compared with the 4-port version it adds:
- parametric widths and depths;
- ready/valid backpressure on every interface;
- oversize and malformed packet handling via an error-flagged tag and counter.
Top levels instantiate one instance per port.

Parameters:
DATA_W, 32, data word width
ADDR_W, 12, block address width
BLK_WORDS, 16, words per block (power of 2, >=2)
MAX_BLKS, 16, max blocks per packet; LEN_W = clog2(MAX_BLKS)
FIFO_DEPTH, 32, ingress word FIFO depth (power of 2)
TAG_DEPTH, 2, tag FIFO depth (power of 2)

Ports:
iClk  in  1  clock
iRst_n  in  1  asynchronous active-low reset
iWrSop  in  1  first word of packet, qualified by iWrVld
iWrEop  in  1  last word of packet, qualified by iWrVld
iWrVld  in  1  ingress word valid
iWrData  in  DATA_W  ingress word
oWrRdy  out  1  ingress FIFO not full; a word is accepted when iWrVld&&oWrRdy
iEptyAddr  in  ADDR_W  free block address
iEptyAddrVld  in  1  free address valid
oEptyAddrRcvRdy  out  1  free address accept
oPktData  out  DATA_W  MMU write data
oPktAddr  out  ADDR_W  current block address
oPktDataVld  out  1  MMU write valid
oPktWrLast  out  1  last word written to this block
iMmuRdy  in  1  MMU accept
oLaddr  out  ADDR_W  link-list address (previous block)
oLdata  out  ADDR_W  link-list data (next block)
oLaddrVld  out  1  one-cycle link write pulse, no backpressure
oPktFirAddr  out  ADDR_W  tag: first block address
oPktLen  out  LEN_W  tag: blocks-1
oPktPri  out  3  tag: priority = header word bits [6:4]
oPktDstPort  out  4  tag: destination = header word bits [3:0]
oPktErr  out  1  tag: packet truncated/malformed; downstream frees the chain and does not forward
oPktTagVld  out  1  tag FIFO not empty
iWrrRdy  in  1  tag pop when oPktTagVld&&iWrrRdy
oErrCnt  out  16  saturating count of error tags plus orphan words

Behaviour:
- Reset: all outputs 0, FIFOs emptied, FSM to IDLE, counters 0. Reset mid-packet discards everything with no tag emitted.
- Ingress FIFO: show-ahead, stores {sop,eop,data}. A word written in cycle N is visible in cycle N+1.
- FSM states: IDLE, GET_ADDR, WRITE, TAG, DROP.
- IDLE:
  - Head word with sop -> latch pri/dst from the head word, blk=0, go to GET_ADDR.
  - Head word without sop -> pop it, oErrCnt+1, stay in IDLE.
- GET_ADDR:
  - oEptyAddrRcvRdy=1; wait for iEptyAddrVld.
  - On handshake, cur=iEptyAddr. If blk==0, fir=cur. Otherwise pulse oLaddrVld with oLaddr=prev, oLdata=cur.
  - Go to WRITE with wcnt=0.
- WRITE:
  - oPktDataVld = FIFO not empty; a word transfers on oPktDataVld&&iMmuRdy; oPktAddr=cur.
  - oPktWrLast = (wcnt==BLK_WORDS-1) || head eop.
  - Head sop while blk>0 or wcnt>0 -> do not pop, go to TAG with err=1.
  - Transfer with eop -> TAG, err=0.
  - Block full, no eop, blk==MAX_BLKS-1 -> DROP with err=1.
  - Block full otherwise -> prev=cur, blk+1, go to GET_ADDR.
- DROP:
  - Pop words until an eop word, inclusive, then go to TAG.
  - Head sop -> stop without popping, go to TAG.
- TAG:
  - Push {fir, blk, pri, dst, err} when the tag FIFO is not full; otherwise stall. Then go to IDLE.
  - err=1 increments oErrCnt.
- No link write for the last block of a packet.
- Minimum latency, with free address and MMU ready:
  - sop word accepted in N -> GET_ADDR at N+2, first MMU write at N+3.
  - One word per cycle thereafter, plus one GET_ADDR cycle per block boundary.
- Simultaneous tag push and pop when full: the pop frees space and the push proceeds the same cycle.
- oErrCnt saturates at 0xFFFF. A push and an orphan-word increment in the same cycle are impossible because they occur in distinct states.

Test Plan:
- 16-word packet, header 0x35, addr 0x010 -> 16 MMU writes at 0x010, WrLast on word 16, no link write; tag fir=0x010, len=0, pri=3, dst=5, err=0.
- 40-word packet, addrs 0x020/0x021/0x022 -> link writes (0x020->0x021) and (0x021->0x022); tag len=2; WrLast on words 16, 32, 40.
- 300-word packet (MAX_BLKS=16) -> 256 words written, 44 dropped, tag len=15, err=1, oErrCnt=1.
- iEptyAddrVld held low 10 cycles, then iMmuRdy toggled -> no data loss; oWrRdy falls after 32 buffered words; data order preserved.
- sop at word 5 of an unterminated packet, then a valid 3-word packet -> tag err=1, len=0, then a clean tag; two stray non-sop words -> oErrCnt +2.
- iWrrRdy=0 with three packets -> two tags queued, FSM stalls in TAG; raise iWrrRdy -> tags pop in order; reset mid-WRITE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/unpack_sg_dma_chan.sv
// Single-channel scatter-gather unpacker.
// Buffers one ingress packet stream and cuts each packet into BLK_WORDS-word
// blocks placed at addresses taken from the free list. Block data goes to the
// MMU, the block chain goes to the link-list SRAM, and a tag FIFO emits one
// tag per packet. Oversize and malformed packets produce an error-flagged tag.
module unpack_sg_dma_chan #(
    parameter int  DATA_W     = 32,
    parameter int  ADDR_W     = 12,
    parameter int  BLK_WORDS  = 16,
    parameter int  MAX_BLKS   = 16,
    parameter int  FIFO_DEPTH = 32,
    parameter int  TAG_DEPTH  = 2,
    localparam int LEN_W      = $clog2(MAX_BLKS)
) (
    input  logic              iClk,
    input  logic              iRst_n,
    // ingress word stream
    input  logic              iWrSop,
    input  logic              iWrEop,
    input  logic              iWrVld,
    input  logic [DATA_W-1:0] iWrData,
    output logic              oWrRdy,
    // free block address list
    input  logic [ADDR_W-1:0] iEptyAddr,
    input  logic              iEptyAddrVld,
    output logic              oEptyAddrRcvRdy,
    // MMU block write
    output logic [DATA_W-1:0] oPktData,
    output logic [ADDR_W-1:0] oPktAddr,
    output logic              oPktDataVld,
    output logic              oPktWrLast,
    input  logic              iMmuRdy,
    // link-list write
    output logic [ADDR_W-1:0] oLaddr,
    output logic [ADDR_W-1:0] oLdata,
    output logic              oLaddrVld,
    // packet tag
    output logic [ADDR_W-1:0] oPktFirAddr,
    output logic [LEN_W-1:0]  oPktLen,
    output logic [2:0]        oPktPri,
    output logic [3:0]        oPktDstPort,
    output logic              oPktErr,
    output logic              oPktTagVld,
    input  logic              iWrrRdy,
    output logic [15:0]       oErrCnt
);

    localparam int FP_W = $clog2(FIFO_DEPTH);
    localparam int TP_W = $clog2(TAG_DEPTH);
    localparam int WC_W = $clog2(BLK_WORDS);

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct packed {
        logic [ADDR_W-1:0] fir;
        logic [LEN_W-1:0]  len;
        logic [2:0]        pri;
        logic [3:0]        dst;
        logic              err;
    } tag_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        WRITE    = 3'd2,
        TAG      = 3'd3,
        DROP     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Ingress word FIFO (show-ahead)
    // ------------------------------------------------------------------
    word_t           fifo_mem [FIFO_DEPTH];
    logic [FP_W:0]   wptr_q, rptr_q;
    logic            fifo_empty, fifo_full, fifo_push, fifo_pop;
    word_t           head;
    logic            rdy_en_q;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = ((wptr_q - rptr_q) == (FP_W+1)'(FIFO_DEPTH));
    assign head       = fifo_mem[rptr_q[FP_W-1:0]];
    // Ready is held low while reset is asserted so every output idles at 0.
    assign oWrRdy     = rdy_en_q && !fifo_full;
    assign fifo_push  = iWrVld && oWrRdy;

    // Ready enable comes up one cycle after reset release
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) rdy_en_q <= 1'b0;
        else         rdy_en_q <= 1'b1;
    end

    // FIFO storage; contents need no reset, the pointers define validity
    always_ff @(posedge iClk) begin
        if (fifo_push) fifo_mem[wptr_q[FP_W-1:0]] <= '{sop: iWrSop, eop: iWrEop, data: iWrData};
    end

    // FIFO pointers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (fifo_push) wptr_q <= wptr_q + 1'b1;
            if (fifo_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    tag_t            tag_mem [TAG_DEPTH];
    logic [TP_W:0]   twptr_q, trptr_q;
    logic            tag_empty, tag_full, tag_push, tag_pop;
    tag_t            tag_head, tag_new;

    assign tag_empty  = (twptr_q == trptr_q);
    assign tag_full   = ((twptr_q - trptr_q) == (TP_W+1)'(TAG_DEPTH));
    assign tag_pop    = !tag_empty && iWrrRdy;
    assign tag_head   = tag_empty ? '0 : tag_mem[trptr_q[TP_W-1:0]];

    assign oPktTagVld  = !tag_empty;
    assign oPktFirAddr = tag_head.fir;
    assign oPktLen     = tag_head.len;
    assign oPktPri     = tag_head.pri;
    assign oPktDstPort = tag_head.dst;
    assign oPktErr     = tag_head.err;

    // Tag storage
    always_ff @(posedge iClk) begin
        if (tag_push) tag_mem[twptr_q[TP_W-1:0]] <= tag_new;
    end

    // Tag pointers; a pop on a full FIFO frees the slot for a same-cycle push
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            twptr_q <= '0;
            trptr_q <= '0;
        end else begin
            if (tag_push) twptr_q <= twptr_q + 1'b1;
            if (tag_pop)  trptr_q <= trptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Segmentation FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d, prev_q, prev_d, fir_q, fir_d;
    logic [LEN_W-1:0]  blk_q, blk_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [2:0]        pri_q, pri_d;
    logic [3:0]        dst_q, dst_d;
    logic              err_q, err_d;
    logic [15:0]       errcnt_q;
    logic              errcnt_inc;
    logic              blk_full;

    assign tag_new  = '{fir: fir_q, len: blk_q, pri: pri_q, dst: dst_q, err: err_q};
    assign oPktAddr = cur_q;
    assign oErrCnt  = errcnt_q;
    assign blk_full = (wcnt_q == WC_W'(BLK_WORDS-1));

    // FSM state and packet context registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            prev_q  <= '0;
            fir_q   <= '0;
            blk_q   <= '0;
            wcnt_q  <= '0;
            pri_q   <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            fir_q   <= fir_d;
            blk_q   <= blk_d;
            wcnt_q  <= wcnt_d;
            pri_q   <= pri_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
        end
    end

    // Saturating error counter: error tags and orphan words
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                               errcnt_q <= '0;
        else if (errcnt_inc && errcnt_q != 16'hFFFF) errcnt_q <= errcnt_q + 16'd1;
    end

    // Next-state and output decode
    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        prev_d          = prev_q;
        fir_d           = fir_q;
        blk_d           = blk_q;
        wcnt_d          = wcnt_q;
        pri_d           = pri_q;
        dst_d           = dst_q;
        err_d           = err_q;
        fifo_pop        = 1'b0;
        tag_push        = 1'b0;
        errcnt_inc      = 1'b0;
        oEptyAddrRcvRdy = 1'b0;
        oPktDataVld     = 1'b0;
        oPktWrLast      = 1'b0;
        oPktData        = '0;
        oLaddrVld       = 1'b0;
        oLaddr          = '0;
        oLdata          = '0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head.sop) begin
                        pri_d   = head.data[6:4];
                        dst_d   = head.data[3:0];
                        blk_d   = '0;
                        err_d   = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        // word outside any packet: discard and count
                        fifo_pop   = 1'b1;
                        errcnt_inc = 1'b1;
                    end
                end
            end

            GET_ADDR: begin
                oEptyAddrRcvRdy = 1'b1;
                if (iEptyAddrVld) begin
                    cur_d  = iEptyAddr;
                    wcnt_d = '0;
                    if (blk_q == '0) begin
                        fir_d = iEptyAddr;
                    end else begin
                        // chain the previous block to this one
                        oLaddrVld = 1'b1;
                        oLaddr    = prev_q;
                        oLdata    = iEptyAddr;
                    end
                    state_d = WRITE;
                end
            end

            WRITE: begin
                if (!fifo_empty) begin
                    if (head.sop && (blk_q != '0 || wcnt_q != '0)) begin
                        // next packet started before this one ended; leave it queued
                        err_d   = 1'b1;
                        state_d = TAG;
                    end else begin
                        oPktDataVld = 1'b1;
                        oPktData    = head.data;
                        oPktWrLast  = blk_full || head.eop;
                        if (iMmuRdy) begin
                            fifo_pop = 1'b1;
                            wcnt_d   = wcnt_q + 1'b1;
                            if (head.eop) begin
                                err_d   = 1'b0;
                                state_d = TAG;
                            end else if (blk_full) begin
                                if (blk_q == LEN_W'(MAX_BLKS-1)) begin
                                    err_d   = 1'b1;
                                    state_d = DROP;
                                end else begin
                                    prev_d  = cur_q;
                                    blk_d   = blk_q + 1'b1;
                                    state_d = GET_ADDR;
                                end
                            end
                        end
                    end
                end
            end

            DROP: begin
                if (!fifo_empty) begin
                    if (head.sop) begin
                        state_d = TAG;
                    end else begin
                        fifo_pop = 1'b1;
                        if (head.eop) state_d = TAG;
                    end
                end
            end

            TAG: begin
                if (!tag_full || tag_pop) begin
                    tag_push   = 1'b1;
                    errcnt_inc = err_q;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
